cook_timer: RTL
===============

// Module: cook_timer
// PURPOSE
//   Cook-time countdown for the microwave; the counterpart of the magnetron controller.
//   Holds a keypad-entered MM:SS time in four BCD digits and counts down only while mag_on=1.
//   On reaching 00:00 it raises timer_done, which the magnetron controller uses to reset mag_on.
//   Digit outputs feed the display decoders.
// PARAMETERS
//   TICK_DIV  100  clk cycles per 1-second tick (synthesis uses board clock rate; sims use small values)
//   CNT_W     7    prescaler width; must satisfy 2**CNT_W >= TICK_DIV
// PORTS
//   clk         in   1  system clock, all state updates on rising edge
//   rst         in   1  synchronous reset, active-high
//   clearn      in   1  clear key, active-low, level-sensitive
//   load_en     in   1  one-cycle strobe: keypad digit valid
//   load_digit  in   4  keypad digit, BCD
//   mag_on      in   1  magnetron running (from magnetron controller)
//   min_tens    out  4  BCD display digit
//   min_ones    out  4  BCD display digit
//   sec_tens    out  4  BCD display digit
//   sec_ones    out  4  BCD display digit
//   timer_done  out  1  registered; high from 00:00 reached until cleared
//   running     out  1  registered; high while in RUN state
// BEHAVIOUR
//   Reset: all digits 0, timer_done=0, running=0, prescaler=0, state IDLE.
//   Priority each edge: rst > clearn=0 > load > count.
//   clearn=0: digits<=0, prescaler<=0, timer_done<=0, state<=IDLE; holds as long as clearn=0.
//   States:
//     IDLE: time==00:00, not done. Load -> ARMED. mag_on=1 -> DONE (timer_done=1 next edge).
//     ARMED: time!=00:00. Load accepted. mag_on=1 -> RUN.
//     RUN: running=1. Prescaler increments each cycle; at TICK_DIV-1 it wraps to 0 and time
//       decrements on that same edge. mag_on=0 -> ARMED, prescaler HOLDS its value (resume keeps phase).
//       Decrement to 00:00 -> DONE on same edge; timer_done=1 from that edge.
//     DONE: timer_done=1, running=0, no counting even if mag_on=1. Exit only via clearn=0,
//       or a valid load, which clears done, zeroes digits, shifts in the digit, goes ARMED
//       (IDLE if digit=0).
//   Load (valid only when load_en=1, load_digit<=9, state!=RUN):
//     shift left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones,
//     sec_ones<=load_digit. The old min_tens is dropped. load_digit>9 is ignored entirely.
//     load_en during RUN is ignored. After load, state = (time==0) ? IDLE : ARMED.
//   Decrement (BCD, MM:SS):
//     sec_ones>0 -> sec_ones-1.
//     Otherwise sec_ones=9 and sec_tens-1; if sec_tens was 0, set sec_tens=5 and borrow a minute.
//     Minute borrow: min_ones>0 -> min_ones-1; else min_ones=9, min_tens-1.
//     The seconds field may be entered as 60..99 (e.g. 0:90 counts 90 s). Wrap after a borrow is always 59.
//   Simultaneous: clearn=0 with load_en -> clear wins. A tick with mag_on falling on the same
//     edge still counts, because mag_on is sampled at that edge.
//   Outputs never show a non-BCD digit.
// TESTING (TICK_DIV=4)
//   Reset: rst=1 for 2 cycles with mag_on=1 -> digits 0000, timer_done=0, running=0.
//   Load 1,3,0 -> display 01:30, ARMED. mag_on=1 -> after 4 cycles shows 01:29.
//     After 124 cycles total shows 00:59.
//   Load 5 -> 00:05. mag_on=1 -> timer_done=1 exactly 20 cycles later, running=0; mag_on
//     stays 1 for 10 more cycles -> display stays 00:00.
//   Pause: 00:03, mag_on=1 for 6 cycles (00:02, prescaler=2), mag_on=0 for 10 cycles,
//     then mag_on=1 -> next decrement after 2 cycles.
//   Load during RUN and digit 0xA -> both ignored. clearn=0 together with load_en -> 00:00,
//     IDLE. mag_on=1 in IDLE -> timer_done=1 next edge.
//   DONE, then load 7 -> timer_done=0, display 00:07, ARMED. Load 5 digits 1,2,3,4,5 -> 23:45.

Source files
------------

// File: rtl/cook_timer.sv
// -----------------------------------------------------------------------------
// cook_timer
//
// Cook-time countdown for the microwave oven. The user keys in an MM:SS time
// one BCD digit at a time (digits shift in from the right). The time counts
// down once per second only while the magnetron is on. On reaching 00:00 the
// block raises timer_done, which the magnetron controller uses to drop mag_on.
//
// Parameters
//   TICK_DIV   clk cycles per one-second tick
//   CNT_W      prescaler width, 2**CNT_W must be >= TICK_DIV
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous reset, active-high
//   clearn       clear key, active-low, level-sensitive
//   load_en      one-cycle strobe, load_digit is valid
//   load_digit   keypad digit (BCD); values above 9 are ignored
//   mag_on       magnetron running, from the magnetron controller
//   min_tens     display digit, BCD
//   min_ones     display digit, BCD
//   sec_tens     display digit, BCD
//   sec_ones     display digit, BCD
//   timer_done   registered, high from 00:00 reached until cleared or reloaded
//   running      registered, high while counting down
// -----------------------------------------------------------------------------
module cook_timer #(
   parameter int TICK_DIV = 100,
   parameter int CNT_W    = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clearn,
   input  logic             load_en,
   input  logic [3:0]       load_digit,
   input  logic             mag_on,
   output logic [3:0]       min_tens,
   output logic [3:0]       min_ones,
   output logic [3:0]       sec_tens,
   output logic [3:0]       sec_ones,
   output logic             timer_done,
   output logic             running
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

   // Time is held as {min_tens, min_ones, sec_tens, sec_ones}.
   state_t           state_q, state_d;
   logic [15:0]      time_q, time_d;
   logic [CNT_W-1:0] presc_q, presc_d;
   logic             done_q, done_d;
   logic             running_q, running_d;

   logic             loadValid;
   logic [15:0]      loadBase;
   logic [15:0]      loadTime;
   logic [15:0]      decTime;
   logic             tick;
   logic             counting;

   // One-second BCD decrement of MM:SS. A seconds field entered as 60..99
   // simply counts down through those values; a borrow always wraps to 59.
   always_comb begin
      decTime = time_q;
      if (time_q[3:0] != 4'd0) begin
         decTime[3:0] = time_q[3:0] - 4'd1;
      end else begin
         decTime[3:0] = 4'd9;
         if (time_q[7:4] != 4'd0) begin
            decTime[7:4] = time_q[7:4] - 4'd1;
         end else begin
            decTime[7:4] = 4'd5;
            if (time_q[11:8] != 4'd0) begin
               decTime[11:8] = time_q[11:8] - 4'd1;
            end else begin
               decTime[11:8]  = 4'd9;
               decTime[15:12] = time_q[15:12] - 4'd1;
            end
         end
      end
   end

   // Keypad shift: the oldest digit falls off the left. Loading from DONE
   // starts from a blank display rather than the exhausted 00:00.
   always_comb begin
      loadValid = load_en && (load_digit <= 4'd9) && (state_q != RUN);
      loadBase  = (state_q == DONE) ? 16'h0000 : time_q;
      loadTime  = {loadBase[11:0], load_digit};
   end

   // Counting happens on any edge where mag_on is sampled high in ARMED or
   // RUN, so the edge that starts the run already advances the prescaler.
   always_comb begin
      counting = mag_on && ((state_q == ARMED) || (state_q == RUN));
      tick     = counting && (presc_q == PRESC_LAST);
   end

   // Next-state logic. Priority: clear, then keypad load, then counting.
   always_comb begin
      state_d = state_q;
      time_d  = time_q;
      presc_d = presc_q;

      if (!clearn) begin
         state_d = IDLE;
         time_d  = 16'h0000;
         presc_d = '0;
      end else if (loadValid) begin
         time_d  = loadTime;
         state_d = (loadTime == 16'h0000) ? IDLE : ARMED;
      end else begin
         case (state_q)
            IDLE: begin
               if (mag_on) begin
                  state_d = DONE;
               end
            end
            ARMED, RUN: begin
               if (counting) begin
                  state_d = RUN;
                  if (tick) begin
                     presc_d = '0;
                     time_d  = decTime;
                     if (decTime == 16'h0000) begin
                        state_d = DONE;
                     end
                  end else begin
                     presc_d = presc_q + 1'b1;
                  end
               end else begin
                  // Pausing keeps the prescaler so a resume keeps its phase.
                  state_d = ARMED;
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      done_d    = (state_d == DONE);
      running_d = (state_d == RUN);
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         time_q    <= 16'h0000;
         presc_q   <= '0;
         done_q    <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         time_q    <= time_d;
         presc_q   <= presc_d;
         done_q    <= done_d;
         running_q <= running_d;
      end
   end

   assign min_tens   = time_q[15:12];
   assign min_ones   = time_q[11:8];
   assign sec_tens   = time_q[7:4];
   assign sec_ones   = time_q[3:0];
   assign timer_done = done_q;
   assign running    = running_q;

endmodule
